// File: rtl/pmf_alu_scheduler.sv
// Issue scheduler for the shared add/sub unit: picks a ready RS entry, runs add or invert+add, holds the result on the CDB.
// Define PMF_SCHED_RR_EN for round-robin selection; otherwise lowest index wins.
module pmf_alu_scheduler #(
   parameter int NUM_RS = 3,
   parameter int TAG_W  = 4
) (
   input  logic                      clk,
   input  logic                      nRST,
   input  logic [NUM_RS-1:0]         rs_req,
   input  logic [NUM_RS-1:0]         rs_op,
   input  logic [NUM_RS*32-1:0]      rs_data1,
   input  logic [NUM_RS*32-1:0]      rs_data2,
   input  logic [NUM_RS*TAG_W-1:0]   rs_tag,
   output logic [NUM_RS-1:0]         rs_grant,
   output logic [1:0]                alu_state,
   output logic [31:0]               alu_data1,
   output logic [31:0]               alu_data2,
   output logic                      alu_cin,
   input  logic [31:0]               alu_result,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [31:0]               cdb_data,
   input  logic                      cdb_ack,
   output logic                      busy
);

   localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      INV  = 2'd2,
      MADD = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [31:0]       op1_reg, op2_reg, cdb_data_reg;
   logic [TAG_W-1:0]  tag_reg;

   logic              issue_window, issue;
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic [31:0]       sel_d1, sel_d2;
   logic [TAG_W-1:0]  sel_tag;
   logic              sel_op;
   logic              result_valid;

   logic [31:0]       req_d1  [NUM_RS];
   logic [31:0]       req_d2  [NUM_RS];
   logic [TAG_W-1:0]  req_tag [NUM_RS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RS; gi++) begin : g_unpack
         assign req_d1[gi]  = rs_data1[32*gi +: 32];
         assign req_d2[gi]  = rs_data2[32*gi +: 32];
         assign req_tag[gi] = rs_tag[TAG_W*gi +: TAG_W];
      end
   endgenerate

`ifdef PMF_SCHED_RR_EN
   logic [IDX_W-1:0] rr_ptr_reg;

   // Search starts at the pointer and wraps once around the RS entries.
   always_comb begin
      logic [IDX_W:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int off = 0; off < NUM_RS; off++) begin
         cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(off);
         if (cand >= (IDX_W+1)'(NUM_RS))
            cand = cand - (IDX_W+1)'(NUM_RS);
         if (!pick_found && rs_req[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)
         rr_ptr_reg <= '0;
      else if (issue)
         rr_ptr_reg <= (pick_idx == IDX_W'(NUM_RS-1)) ? '0 : pick_idx + IDX_W'(1);
   end
`else
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = NUM_RS-1; i >= 0; i--) begin
         if (rs_req[i]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
   end
`endif

   assign sel_d1  = req_d1[pick_idx];
   assign sel_d2  = req_d2[pick_idx];
   assign sel_tag = req_tag[pick_idx];
   assign sel_op  = rs_op[pick_idx];

   assign result_valid = (state_reg == ADD) || (state_reg == MADD);
   assign issue_window = (state_reg == IDLE) || (result_valid && cdb_ack);
   assign issue        = nRST && issue_window && pick_found;

   generate
      for (gi = 0; gi < NUM_RS; gi++) begin : g_grant
         assign rs_grant[gi] = issue && (pick_idx == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      if (issue_window) begin
         if (issue)
            state_next = sel_op ? INV : ADD;
         else
            state_next = IDLE;
      end else if (state_reg == INV) begin
         state_next = MADD;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         op1_reg      <= '0;
         op2_reg      <= '0;
         tag_reg      <= '0;
         cdb_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (issue) begin
            op1_reg <= sel_d1;
            op2_reg <= sel_d2;
            tag_reg <= sel_tag;
         end
         if ((issue && !sel_op) || (state_reg == INV))
            cdb_data_reg <= alu_result;
      end
   end

   // On an issue cycle the adder already sees the winner's operands, so an add
   // result can be captured on the very edge that enters ADD.
   always_comb begin
      if (issue) begin
         alu_data1 = sel_d1;
         alu_data2 = sel_d2;
         alu_cin   = 1'b0;
      end else begin
         alu_data1 = op1_reg;
         alu_data2 = (state_reg == INV) ? ~op2_reg : op2_reg;
         alu_cin   = (state_reg == INV) || (state_reg == MADD);
      end
   end

   assign alu_state = state_reg;
   assign cdb_valid = result_valid;
   assign cdb_tag   = tag_reg;
   assign cdb_data  = cdb_data_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pmf_alu_scheduler.sv
// Bench for pmf_alu_scheduler: RS/adder environment, scoreboard queue of expected CDB results, randomized traffic.
module tb_pmf_alu_scheduler;
   localparam int NUM_RS = 3;
   localparam int TAG_W  = 4;

   logic                     clk = 1'b0;
   logic                     nRST;
   logic [NUM_RS-1:0]        rs_req, rs_op, rs_grant;
   logic [NUM_RS*32-1:0]     rs_data1, rs_data2;
   logic [NUM_RS*TAG_W-1:0]  rs_tag;
   logic [1:0]               alu_state;
   logic [31:0]              alu_data1, alu_data2, alu_result, cdb_data;
   logic                     alu_cin, cdb_valid, cdb_ack, busy;
   logic [TAG_W-1:0]         cdb_tag;

   pmf_alu_scheduler #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) dut (
      .clk(clk), .nRST(nRST),
      .rs_req(rs_req), .rs_op(rs_op), .rs_data1(rs_data1), .rs_data2(rs_data2),
      .rs_tag(rs_tag), .rs_grant(rs_grant),
      .alu_state(alu_state), .alu_data1(alu_data1), .alu_data2(alu_data2),
      .alu_cin(alu_cin), .alu_result(alu_result),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_ack(cdb_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // The shared adder the scheduler drives.
   assign alu_result = alu_data1 + alu_data2 + {31'd0, alu_cin};

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      int               gcyc;
      int               due;
      bit               sub;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   bit               pend_v   [NUM_RS];
   bit               pend_op  [NUM_RS];
   logic [31:0]      pend_d1  [NUM_RS];
   logic [31:0]      pend_d2  [NUM_RS];
   logic [TAG_W-1:0] pend_tag [NUM_RS];
   bit               cool     [NUM_RS];

   int refill_pct = 0, sub_pct = 50, ack_pct = 0, drop_pct = 0;
   bit rst_req    = 1'b1;
   bit inflight   = 1'b0;
   int ready_cyc  = 0;
   int rr_ptr_m   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0000_0001;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_op(input int i, input bit op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [TAG_W-1:0] tag);
      pend_v[i]   = 1'b1;
      pend_op[i]  = op;
      pend_d1[i]  = d1;
      pend_d2[i]  = d2;
      pend_tag[i] = tag;
   endtask

   // One clock cycle of the RS environment: drive, predict the grant, update the model.
   task automatic step();
      logic [NUM_RS-1:0] exp_g;
      exp_t              e;
      int                k, start, idx;
      bit                free, result_taken;
      #1;
      nRST = !rst_req;
      if (rst_req) begin
         sb_q.delete();
         inflight = 1'b0;
         rr_ptr_m = 0;
      end
      for (int i = 0; i < NUM_RS; i++) begin
         if (cool[i])
            cool[i] = 1'b0;
         else if (!pend_v[i] && $urandom_range(0, 99) < refill_pct)
            set_op(i, $urandom_range(0, 99) < sub_pct, rand_data(), rand_data(), TAG_W'($urandom));
         else if (pend_v[i] && $urandom_range(0, 99) < drop_pct)
            pend_v[i] = 1'b0;
         rs_req[i]                  = pend_v[i];
         rs_op[i]                   = pend_op[i];
         rs_data1[32*i +: 32]       = pend_d1[i];
         rs_data2[32*i +: 32]       = pend_d2[i];
         rs_tag[TAG_W*i +: TAG_W]   = pend_tag[i];
      end
      cdb_ack = ($urandom_range(0, 99) < ack_pct);
      #2;
      exp_g = '0;
      k     = -1;
      if (nRST) begin
         result_taken = inflight && (cyc >= ready_cyc) && cdb_ack;
         free = !inflight || result_taken;
         if (free) begin
`ifdef PMF_SCHED_RR_EN
            start = rr_ptr_m;
`else
            start = 0;
`endif
            for (int off = 0; off < NUM_RS; off++) begin
               idx = (start + off) % NUM_RS;
               if (k < 0 && pend_v[idx]) k = idx;
            end
         end
         if (k >= 0) exp_g[k] = 1'b1;
         if (result_taken) inflight = 1'b0;
      end else begin
         check("reset_cdb_tag", 32'(cdb_tag), 32'd0);
         check("reset_cdb_data", cdb_data, 32'd0);
         check("reset_alu_data1", alu_data1, 32'd0);
         check("reset_alu_data2", alu_data2, 32'd0);
         check("reset_alu_cin", 32'(alu_cin), 32'd0);
      end
      check("rs_grant", 32'(rs_grant), 32'(exp_g));
      if (k >= 0) begin
         e.tag  = pend_tag[k];
         e.data = pend_op[k] ? (pend_d1[k] - pend_d2[k]) : (pend_d1[k] + pend_d2[k]);
         e.gcyc = cyc;
         e.due  = cyc + (pend_op[k] ? 2 : 1);
         e.sub  = pend_op[k];
         sb_q.push_back(e);
         pend_v[k] = 1'b0;
         cool[k]   = 1'b1;
         inflight  = 1'b1;
         ready_cyc = e.due;
         rr_ptr_m  = (k + 1) % NUM_RS;
      end
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int s = 0; s < n; s++) step();
   endtask

   // Monitor: compares whatever the DUT presents against the head of the scoreboard.
   always @(negedge clk) begin
      logic       exp_v;
      logic [1:0] exp_st;
      #4;
      exp_v  = 1'b0;
      exp_st = 2'd0;
      if (sb_q.size() > 0 && cyc != sb_q[0].gcyc) begin
         if (cyc >= sb_q[0].due) begin
            exp_v  = 1'b1;
            exp_st = sb_q[0].sub ? 2'd3 : 2'd1;
         end else begin
            exp_st = 2'd2;
         end
      end
      check("cdb_valid", 32'(cdb_valid), 32'(exp_v));
      check("alu_state", 32'(alu_state), 32'(exp_st));
      check("busy", 32'(busy), 32'(exp_st != 2'd0));
      if (exp_v && cdb_valid) begin
         check("cdb_tag", 32'(cdb_tag), 32'(sb_q[0].tag));
         check("cdb_data", cdb_data, sb_q[0].data);
         if (cdb_ack) begin
            $display("cdb accept: tag=%0d data=0x%08h %s cycle=%0d",
                     cdb_tag, cdb_data, sb_q[0].sub ? "sub" : "add", cyc);
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      nRST     = 1'b0;
      cdb_ack  = 1'b0;
      rs_req   = '0;
      rs_op    = '0;
      rs_data1 = '0;
      rs_data2 = '0;
      rs_tag   = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         pend_v[i] = 1'b0; pend_op[i] = 1'b0; cool[i] = 1'b0;
         pend_d1[i] = '0; pend_d2[i] = '0; pend_tag[i] = '0;
      end
      @(negedge clk);

      // Reset with a request pending: no grant while held.
      set_op(0, 1'b0, 32'd9, 32'd1, 4'd1);
      rst_req = 1'b1; steps(2);
      rst_req = 1'b0; ack_pct = 100; steps(3);

      // Add 5+7, tag 3, accepted immediately.
      set_op(0, 1'b0, 32'd5, 32'd7, 4'd3);
      steps(4);

      // Sub 5-7 held three cycles without ack.
      set_op(1, 1'b1, 32'd5, 32'd7, 4'd5);
      ack_pct = 0; steps(5);
      ack_pct = 100; steps(2);

      // Back-to-back: entry2 issued in the ack cycle of entry0's add.
      ack_pct = 0;
      set_op(0, 1'b0, 32'd10, 32'd20, 4'd1);
      step();
      set_op(2, 1'b0, 32'd3, 32'd4, 4'd2);
      step();
      ack_pct = 100; steps(4);

      // Wrap-around arithmetic.
      set_op(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd6);
      set_op(1, 1'b1, 32'd0, 32'd1, 4'd7);
      steps(6);

      // Reset in the middle of a subtract.
      ack_pct = 0;
      set_op(2, 1'b1, 32'd100, 32'd1, 4'd8);
      steps(3);
      set_op(0, 1'b0, 32'd2, 32'd2, 4'd9);
      rst_req = 1'b1; steps(2);
      rst_req = 1'b0; ack_pct = 100; steps(4);

      // Arbitration with every entry requesting continuously.
      for (int i = 0; i < NUM_RS; i++) set_op(i, 1'b1, rand_data(), rand_data(), TAG_W'(i));
      refill_pct = 100; sub_pct = 100; steps(14);
      sub_pct = 0; steps(10);

      // Randomized traffic.
      refill_pct = 40; sub_pct = 50; ack_pct = 60; drop_pct = 5;
      steps(2000);

      // Drain.
      refill_pct = 0; drop_pct = 0; ack_pct = 100;
      steps(12);
      check("drain_queue_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
